// File: rtl/seq_shift_register_if.sv
// Control/data bundle for seq_shift_register: load/start controls in, register state and handshake out.
interface seq_shift_register_if #(
    parameter int unsigned x  = 8,
    parameter int unsigned CW = 4
);
    logic          load;
    logic [x-1:0]  data_in;
    logic          start;
    logic [1:0]    op;
    logic [CW-1:0] amount;
    logic          serial_in;
    logic [x-1:0]  q;
    logic          serial_out;
    logic          busy;
    logic          done;

    modport master (
        output load, data_in, start, op, amount, serial_in,
        input  q, serial_out, busy, done
    );

    modport slave (
        input  load, data_in, start, op, amount, serial_in,
        output q, serial_out, busy, done
    );
endinterface

// File: rtl/seq_shift_register.sv
// Parallel-load register with a multi-cycle shift/rotate sequencer (one bit step per clock)
// and a busy/done handshake.
module seq_shift_register #(
    parameter int unsigned x  = 8,
    parameter int unsigned CW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_shift_register_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [x-1:0]  q_q, q_d;
    logic          so_q, so_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State, sequencer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
            q_q     <= '0;
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_q     <= q_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state: load aborts; start is only honoured from IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (bus.load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_d = bus.op;
                        if (bus.amount != '0) begin
                            state_d = SHIFT;
                            cnt_d   = bus.amount;
                        end
                    end
                end
                SHIFT: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Next register contents and handshake; busy drops on the final step so done never overlaps it
    always_comb begin
        q_d    = q_q;
        so_d   = so_q;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (bus.load) begin
            q_d = bus.data_in;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                if (bus.amount == '0) begin
                    done_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
        end else begin
            unique case (op_q)
                OP_SLL: begin
                    q_d  = {q_q[x-2:0], bus.serial_in};
                    so_d = q_q[x-1];
                end
                OP_SRL: begin
                    q_d  = {bus.serial_in, q_q[x-1:1]};
                    so_d = q_q[0];
                end
                OP_SRA: begin
                    q_d  = {q_q[x-1], q_q[x-1:1]};
                    so_d = q_q[0];
                end
                OP_ROR: begin
                    q_d  = {q_q[0], q_q[x-1:1]};
                    so_d = q_q[0];
                end
                default: begin
                    q_d  = q_q;
                    so_d = so_q;
                end
            endcase
            if (cnt_q == CW'(1)) begin
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end
    end

    assign bus.q          = q_q;
    assign bus.serial_out = so_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_seq_shift_register.sv
// Directed scoreboard bench for seq_shift_register: expected per-cycle state is queued as stimulus
// is driven and popped against the DUT one edge later.
module tb_seq_shift_register;
    logic clk;
    logic rst;

    seq_shift_register_if #(.x(8), .CW(4)) bus ();

    seq_shift_register #(.x(8), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model of the register contents and serial output
    logic [7:0] mq;
    logic       mso;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_step(input logic [1:0] o, input logic [7:0] v,
                                            input logic sin, output logic so);
        logic [7:0] r;
        case (o)
            2'b00:   begin so = v[7]; r = {v[6:0], sin}; end
            2'b01:   begin so = v[0]; r = {sin, v[7:1]}; end
            2'b10:   begin so = v[0]; r = {v[7], v[7:1]}; end
            default: begin so = v[0]; r = {v[0], v[7:1]}; end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation for the coming edge, advance, then pop and compare
    task automatic cyc(input string tag, input logic busy_e, input logic done_e);
        exp_t  e;
        exp_t  obs;
        string t;
        exp_q.push_back('{q: mq, so: mso, busy: busy_e, done: done_e});
        tag_q.push_back(tag);
        tick();
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = '{q: bus.q, so: bus.serial_out, busy: bus.busy, done: bus.done};
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed q=%h so=%b busy=%b done=%b, expected q=%h so=%b busy=%b done=%b",
                   t, obs.q, obs.so, obs.busy, obs.done, e.q, e.so, e.busy, e.done);
        end
    endtask

    task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] e);
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic do_load(input string tag, input logic [7:0] v);
        bus.load    = 1'b1;
        bus.data_in = v;
        mq          = v;
        cyc(tag, 1'b0, 1'b0);
        bus.load    = 1'b0;
    endtask

    // Start an operation and walk it to its done cycle; op/amount are scrambled while busy
    task automatic run_op(input string tag, input logic [1:0] o, input int amt, input logic sin);
        logic s;
        bus.start     = 1'b1;
        bus.op        = o;
        bus.amount    = 4'(amt);
        bus.serial_in = sin;
        cyc({tag, "_start"}, amt != 0, amt == 0);
        bus.start  = 1'b0;
        bus.op     = ~o;
        bus.amount = 4'd1;
        for (int i = 1; i <= amt; i++) begin
            mq  = ref_step(o, mq, sin, s);
            mso = s;
            cyc({tag, "_step"}, i != amt, i == amt);
        end
    endtask

    initial begin
        logic s;
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.data_in   = 8'h00;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.amount    = 4'd0;
        bus.serial_in = 1'b0;
        mq  = 8'h00;
        mso = 1'b0;

        // Reset and hold
        cyc("reset1", 1'b0, 1'b0);
        cyc("reset2", 1'b0, 1'b0);
        rst = 1'b0;
        do_load("load_b6", 8'hB6);
        bus.data_in = 8'h55;
        cyc("hold1", 1'b0, 1'b0);
        cyc("hold2", 1'b0, 1'b0);

        // SRA by 3
        run_op("sra3", 2'b10, 3, 1'b0);
        chk_val("sra3_q", bus.q, 8'hF6);
        chk_val("sra3_so", {7'b0, bus.serial_out}, 8'h01);
        cyc("sra3_idle", 1'b0, 1'b0);

        // ROR by 4, then by 8 (full turn)
        do_load("load_b6_ror", 8'hB6);
        run_op("ror4", 2'b11, 4, 1'b0);
        chk_val("ror4_q", bus.q, 8'h6B);
        chk_val("ror4_so", {7'b0, bus.serial_out}, 8'h00);
        cyc("ror4_idle", 1'b0, 1'b0);
        run_op("ror8", 2'b11, 8, 1'b0);
        chk_val("ror8_q", bus.q, 8'h6B);
        cyc("ror8_idle", 1'b0, 1'b0);

        // SLL by 2 with serial_in=1, then back-to-back ROR by 1 from the done cycle
        do_load("load_b6_sll", 8'hB6);
        run_op("sll2", 2'b00, 2, 1'b1);
        chk_val("sll2_q", bus.q, 8'hDB);
        chk_val("sll2_so", {7'b0, bus.serial_out}, 8'h00);
        run_op("b2b_ror1", 2'b11, 1, 1'b0);
        chk_val("b2b_q", bus.q, 8'hED);
        cyc("b2b_idle", 1'b0, 1'b0);

        // SRL by 15 clears an all-ones register
        do_load("load_ff", 8'hFF);
        run_op("srl15", 2'b01, 15, 1'b0);
        chk_val("srl15_q", bus.q, 8'h00);
        cyc("srl15_idle", 1'b0, 1'b0);

        // Abort: start ignored while busy, then load kills the operation
        do_load("load_a5", 8'hA5);
        bus.start     = 1'b1;
        bus.op        = 2'b01;
        bus.amount    = 4'd5;
        bus.serial_in = 1'b0;
        cyc("abort_start", 1'b1, 1'b0);
        bus.start = 1'b0;
        mq  = ref_step(2'b01, mq, 1'b0, s);
        mso = s;
        cyc("abort_step1", 1'b1, 1'b0);
        bus.start  = 1'b1;
        bus.op     = 2'b11;
        bus.amount = 4'd1;
        mq  = ref_step(2'b01, mq, 1'b0, s);
        mso = s;
        cyc("abort_ignored_start", 1'b1, 1'b0);
        bus.start = 1'b0;
        do_load("abort_load", 8'h0F);
        chk_val("abort_q", bus.q, 8'h0F);
        cyc("abort_no_done1", 1'b0, 1'b0);
        cyc("abort_no_done2", 1'b0, 1'b0);

        // Start and load together: load wins
        bus.start  = 1'b1;
        bus.op     = 2'b11;
        bus.amount = 4'd2;
        do_load("start_load", 8'h3C);
        bus.start = 1'b0;
        cyc("start_load_idle", 1'b0, 1'b0);

        // amount==0 completes immediately with q untouched
        run_op("amt0", 2'b10, 0, 1'b0);
        chk_val("amt0_q", bus.q, 8'h3C);
        cyc("amt0_idle", 1'b0, 1'b0);

        // Reset during SHIFT
        bus.start  = 1'b1;
        bus.op     = 2'b10;
        bus.amount = 4'd6;
        cyc("rst_mid_start", 1'b1, 1'b0);
        bus.start = 1'b0;
        mq  = ref_step(2'b10, mq, 1'b0, s);
        mso = s;
        cyc("rst_mid_step", 1'b1, 1'b0);
        rst = 1'b1;
        mq  = 8'h00;
        mso = 1'b0;
        cyc("rst_mid_clear", 1'b0, 1'b0);
        rst = 1'b0;
        cyc("rst_mid_no_done1", 1'b0, 1'b0);
        cyc("rst_mid_no_done2", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
